sdram_init_refresh_ctrl: RTL and testbench

SDRAM command sequencer for the SDRAM controller. After reset it runs the JEDEC power-up sequence: NOP wait, PRECHARGE ALL, INIT_AR AUTO REFRESH commands, then LOAD MODE REGISTER, followed by `sdr_init_done`. After that it schedules periodic AUTO REFRESH, using a request/grant handshake with the Wishbone-side main controller. While `sdr_cmd_own` is high it drives the SDRAM command pins; otherwise the main controller's command mux drives them.

---
 rtl/sdram_pkg.sv | 28 ++
 rtl/sdram_wait_timer.sv | 29 ++
 rtl/sdram_init_refresh_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_sdram_init_refresh_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM init/refresh command sequencer.
package sdram_pkg;

    localparam int ADDR_W  = 13;
    localparam int A10_BIT = 10;
    localparam int TIMER_W = 16;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_INHIBIT = 4'b1111,
        CMD_NOP     = 4'b0111,
        CMD_PRE     = 4'b0010,
        CMD_AR      = 4'b0001,
        CMD_LMR     = 4'b0000
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        ST_PWRUP    = 3'd0,
        ST_INIT_PRE = 3'd1,
        ST_INIT_AR  = 3'd2,
        ST_INIT_LMR = 3'd3,
        ST_MRD_WAIT = 3'd4,
        ST_IDLE     = 3'd5,
        ST_REF_PRE  = 3'd6,
        ST_REF_AR   = 3'd7
    } init_state_t;

endpackage

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter; done is high in the last cycle before the count
// reaches zero, so a load of N produces done N cycles after the load edge.
module sdram_wait_timer
    import sdram_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done = (count_q == W'(1));

endmodule

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up sequencer and periodic AUTO REFRESH scheduler; owns the
// command pins during init and during each granted refresh.
module sdram_init_refresh_ctrl
    import sdram_pkg::*;
#(
    parameter int unsigned PWRUP_CYC = 10000,
    parameter int unsigned TRP       = 8,
    parameter int unsigned TRFC      = 10,
    parameter int unsigned INIT_AR   = 16,
    parameter int unsigned TMRD      = 18,
    parameter int unsigned TREFI     = 780,
    parameter int unsigned MAX_PEND  = 8,
    parameter logic [12:0] MODE_REG  = 13'h033
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        ref_gnt,
    output logic        sdr_cs_n,
    output logic        sdr_ras_n,
    output logic        sdr_cas_n,
    output logic        sdr_we_n,
    output logic [12:0] sdr_addr,
    output logic [1:0]  sdr_ba,
    output logic        sdr_cmd_own,
    output logic        sdr_init_done,
    output logic        ref_req,
    output logic        ref_busy,
    output logic [2:0]  dbg_state
);

    localparam int AR_W   = $clog2(INIT_AR + 1);
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    init_state_t       state_q, state_next;
    sdram_cmd_t        cmd_q, cmd_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic              own_q, own_next;
    logic              busy_q, busy_next;
    logic              done_q, done_next;
    logic              armed_q, armed_next;
    logic [AR_W-1:0]   ar_cnt_q, ar_cnt_next;
    logic              gnt_q;
    logic [PEND_W-1:0] pending_q, pend_next;
    logic              ref_overflow, ovf_next;
    logic              req_q;

    logic               cmd_load;
    logic [TIMER_W-1:0] cmd_load_val;
    logic               cmd_done;
    logic               tref_start;
    logic               tref_done;
    logic               ar_issue;

    sdram_wait_timer #(.W(TIMER_W)) u_cmd_timer (
        .clk      (sys_clk),
        .rst_n    (reset_n),
        .load     (cmd_load),
        .load_val (cmd_load_val),
        .done     (cmd_done)
    );

    sdram_wait_timer #(.W(TIMER_W)) u_trefi_timer (
        .clk      (sys_clk),
        .rst_n    (reset_n),
        .load     (tref_start | tref_done),
        .load_val (TIMER_W'(TREFI)),
        .done     (tref_done)
    );

    always_comb begin
        state_next   = state_q;
        cmd_next     = CMD_NOP;
        addr_next    = '0;
        own_next     = own_q;
        busy_next    = busy_q;
        done_next    = done_q;
        armed_next   = armed_q;
        ar_cnt_next  = ar_cnt_q;
        cmd_load     = 1'b0;
        cmd_load_val = '0;
        tref_start   = 1'b0;
        ar_issue     = 1'b0;

        case (state_q)
            ST_PWRUP: begin
                if (!armed_q) begin
                    cmd_load     = 1'b1;
                    cmd_load_val = TIMER_W'(PWRUP_CYC);
                    armed_next   = 1'b1;
                end else if (cmd_done) begin
                    cmd_next           = CMD_PRE;
                    addr_next[A10_BIT] = 1'b1;
                    cmd_load           = 1'b1;
                    cmd_load_val       = TIMER_W'(TRP);
                    state_next         = ST_INIT_PRE;
                end
            end
            ST_INIT_PRE: begin
                if (cmd_done) begin
                    cmd_next     = CMD_AR;
                    cmd_load     = 1'b1;
                    cmd_load_val = TIMER_W'(TRFC);
                    ar_cnt_next  = AR_W'(1);
                    state_next   = ST_INIT_AR;
                end
            end
            ST_INIT_AR: begin
                if (cmd_done) begin
                    cmd_load = 1'b1;
                    if (ar_cnt_q == AR_W'(INIT_AR)) begin
                        cmd_next     = CMD_LMR;
                        addr_next    = MODE_REG;
                        cmd_load_val = TIMER_W'(TMRD);
                        state_next   = ST_INIT_LMR;
                    end else begin
                        cmd_next     = CMD_AR;
                        cmd_load_val = TIMER_W'(TRFC);
                        ar_cnt_next  = ar_cnt_q + AR_W'(1);
                    end
                end
            end
            // INIT_LMR is the first cycle after the mode-register write; the
            // rest of TMRD is spent in MRD_WAIT. Both honour an early expiry.
            ST_INIT_LMR, ST_MRD_WAIT: begin
                if (cmd_done) begin
                    done_next  = 1'b1;
                    own_next   = 1'b0;
                    tref_start = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_MRD_WAIT;
                end
            end
            ST_IDLE: begin
                if (gnt_q) begin
                    cmd_next           = CMD_PRE;
                    addr_next[A10_BIT] = 1'b1;
                    own_next           = 1'b1;
                    busy_next          = 1'b1;
                    cmd_load           = 1'b1;
                    cmd_load_val       = TIMER_W'(TRP);
                    state_next         = ST_REF_PRE;
                end
            end
            ST_REF_PRE: begin
                if (cmd_done) begin
                    cmd_next     = CMD_AR;
                    cmd_load     = 1'b1;
                    cmd_load_val = TIMER_W'(TRFC);
                    ar_issue     = 1'b1;
                    state_next   = ST_REF_AR;
                end
            end
            ST_REF_AR: begin
                if (cmd_done) begin
                    own_next   = 1'b0;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_PWRUP;
        endcase

        if (!own_next) begin
            cmd_next  = CMD_INHIBIT;
            addr_next = '0;
        end
    end

    // An expiry coinciding with a refresh issue cancels out.
    always_comb begin
        pend_next = pending_q;
        ovf_next  = ref_overflow;
        if (tref_done && !ar_issue) begin
            if (pending_q == PEND_W'(MAX_PEND)) begin
                ovf_next = 1'b1;
            end else begin
                pend_next = pending_q + PEND_W'(1);
            end
        end else if (ar_issue && !tref_done && pending_q != '0) begin
            pend_next = pending_q - PEND_W'(1);
        end
    end

    // ref_req/ref_gnt: ref_req stays high while refreshes are pending; a
    // ref_gnt seen high in IDLE with ref_req high after init buys exactly one
    // refresh, started the cycle after the grant is sampled. Grants seen at
    // any other time are dropped.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_PWRUP;
            cmd_q        <= CMD_INHIBIT;
            addr_q       <= '0;
            own_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            armed_q      <= 1'b0;
            ar_cnt_q     <= '0;
            gnt_q        <= 1'b0;
            pending_q    <= '0;
            ref_overflow <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_next;
            cmd_q        <= cmd_next;
            addr_q       <= addr_next;
            own_q        <= own_next;
            busy_q       <= busy_next;
            done_q       <= done_next;
            armed_q      <= armed_next;
            ar_cnt_q     <= ar_cnt_next;
            gnt_q        <= ref_gnt && req_q && done_q && (state_q == ST_IDLE) && !gnt_q;
            pending_q    <= pend_next;
            ref_overflow <= ovf_next;
            req_q        <= (pend_next != '0);
        end
    end

    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
    assign sdr_addr      = addr_q;
    assign sdr_ba        = 2'b00;
    assign sdr_cmd_own   = own_q;
    assign sdr_init_done = done_q;
    assign ref_req       = req_q;
    assign ref_busy      = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Directed bench for the SDRAM init/refresh sequencer with a cycle-by-cycle
// expected queue of {own, busy, cmd, addr}.
module tb_sdram_init_refresh_ctrl;
    import sdram_pkg::*;

    localparam int T_PWRUP = 20;
    localparam int T_RP    = 3;
    localparam int T_RFC   = 10;
    localparam int N_AR    = 2;
    localparam int T_MRD   = 2;
    localparam int T_REFI  = 50;
    localparam int N_PEND  = 2;
    localparam int P_CYC   = T_PWRUP;
    localparam int L_CYC   = T_PWRUP + T_RP + N_AR * T_RFC;
    localparam int D_CYC   = L_CYC + T_MRD;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        ref_gnt;
    logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [12:0] sdr_addr;
    logic [1:0]  sdr_ba;
    logic        sdr_cmd_own, sdr_init_done, ref_req, ref_busy;
    logic [2:0]  dbg_state;

    int n;
    int tests = 0;
    int fails = 0;
    logic [18:0] exp_q[$];

    sdram_init_refresh_ctrl #(
        .PWRUP_CYC (T_PWRUP), .TRP (T_RP), .TRFC (T_RFC), .INIT_AR (N_AR),
        .TMRD (T_MRD), .TREFI (T_REFI), .MAX_PEND (N_PEND), .MODE_REG (13'h033)
    ) dut (
        .sys_clk       (sys_clk),
        .reset_n       (reset_n),
        .ref_gnt       (ref_gnt),
        .sdr_cs_n      (sdr_cs_n),
        .sdr_ras_n     (sdr_ras_n),
        .sdr_cas_n     (sdr_cas_n),
        .sdr_we_n      (sdr_we_n),
        .sdr_addr      (sdr_addr),
        .sdr_ba        (sdr_ba),
        .sdr_cmd_own   (sdr_cmd_own),
        .sdr_init_done (sdr_init_done),
        .ref_req       (ref_req),
        .ref_busy      (ref_busy),
        .dbg_state     (dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [18:0] pins();
        return {sdr_cmd_own, ref_busy, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr};
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
        n++;
    endtask

    task automatic step_to(input int target);
        while (n < target) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag);
        logic [18:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(pins()), 32'(e));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pins"}, 32'(pins()), 32'({1'b1, 1'b0, 4'hF, 13'h0}));
        chk({tag, "_done"}, 32'(sdr_init_done), 32'd0);
        chk({tag, "_req"}, 32'(ref_req), 32'd0);
        chk({tag, "_ba"}, 32'(sdr_ba), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_PWRUP));
        chk({tag, "_pend"}, 32'(dut.pending_q), 32'd0);
        chk({tag, "_ovf"}, 32'(dut.ref_overflow), 32'd0);
    endtask

    // Releases reset and checks cycles 0..last against the power-up timeline;
    // a grant pulse before init completes must leave the sequence untouched.
    task automatic run_init(input int last);
        logic [3:0]  c;
        logic [12:0] a;
        logic        own;
        for (int i = 0; i <= last; i++) begin
            c = CMD_NOP;
            a = 13'h0;
            own = 1'b1;
            if (i == P_CYC) begin
                c = CMD_PRE;
                a = 13'h400;
            end
            for (int k = 0; k < N_AR; k++)
                if (i == P_CYC + T_RP + k * T_RFC) c = CMD_AR;
            if (i == L_CYC) begin
                c = CMD_LMR;
                a = 13'h033;
            end
            if (i >= D_CYC) begin
                own = 1'b0;
                c = CMD_INHIBIT;
            end
            exp_q.push_back({own, 1'b0, c, a});
        end
        @(negedge sys_clk);
        reset_n = 1'b1;
        n = -1;
        for (int i = 0; i <= last; i++) begin
            step();
            pop_cmp("init_cmd");
            if (n == 9) ref_gnt = 1'b1;
            if (n == 12) ref_gnt = 1'b0;
            if (n == D_CYC - 1) chk("init_done_early", 32'(sdr_init_done), 32'd0);
            if (n == D_CYC) chk("init_done", 32'(sdr_init_done), 32'd1);
        end
        ref_gnt = 1'b0;
    endtask

    task automatic do_refresh(input int t);
        step_to(t - 1);
        ref_gnt = 1'b1;
        step();
        ref_gnt = 1'b0;
        for (int i = 1; i <= 1 + T_RP + T_RFC; i++) begin
            if (i == 1)                     exp_q.push_back({1'b1, 1'b1, CMD_PRE, 13'h400});
            else if (i == 1 + T_RP)         exp_q.push_back({1'b1, 1'b1, CMD_AR, 13'h0});
            else if (i == 1 + T_RP + T_RFC) exp_q.push_back({1'b0, 1'b0, CMD_INHIBIT, 13'h0});
            else                            exp_q.push_back({1'b1, 1'b1, CMD_NOP, 13'h0});
        end
        for (int i = 1; i <= 1 + T_RP + T_RFC; i++) begin
            step();
            pop_cmp("ref_cmd");
        end
    endtask

    initial begin
        reset_n = 1'b1;
        ref_gnt = 1'b0;
        n = 0;
        #2 reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_reset_vals("rst_hold");
        end

        run_init(D_CYC);

        // Grant with nothing pending is ignored.
        step_to(50);
        ref_gnt = 1'b1;
        step_to(52);
        ref_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gnt_noreq_pins", 32'(pins()), 32'({1'b0, 1'b0, 4'hF, 13'h0}));
        end

        step_to(D_CYC + T_REFI - 1);
        chk("req_before", 32'(ref_req), 32'd0);
        step();
        chk("req_rise", 32'(ref_req), 32'd1);
        chk("pend_one", 32'(dut.pending_q), 32'd1);

        do_refresh(96);
        chk("req_clear", 32'(ref_req), 32'd0);
        chk("pend_zero", 32'(dut.pending_q), 32'd0);

        // Starve the refresh: expiries at 145, 195, 245.
        step_to(244);
        chk("pend_sat", 32'(dut.pending_q), 32'(N_PEND));
        chk("ovf_before", 32'(dut.ref_overflow), 32'd0);
        step_to(246);
        chk("pend_sat_hold", 32'(dut.pending_q), 32'(N_PEND));
        chk("ovf_set", 32'(dut.ref_overflow), 32'd1);
        chk("req_sat", 32'(ref_req), 32'd1);

        do_refresh(250);
        chk("pend_after1", 32'(dut.pending_q), 32'd1);
        chk("req_after1", 32'(ref_req), 32'd1);
        do_refresh(265);
        chk("pend_after2", 32'(dut.pending_q), 32'd0);
        chk("req_after2", 32'(ref_req), 32'd0);
        chk("ovf_sticky", 32'(dut.ref_overflow), 32'd1);

        // Reset during the init AUTO REFRESH phase.
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst_idle");
        run_init(28);
        chk("mid_init_state", 32'(dbg_state), 32'(ST_INIT_AR));
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst_init_ar");
        run_init(D_CYC);

        // Reset during a refresh AUTO REFRESH wait.
        step_to(95);
        ref_gnt = 1'b1;
        step();
        ref_gnt = 1'b0;
        step_to(101);
        chk("mid_ref_state", 32'(dbg_state), 32'(ST_REF_AR));
        chk("mid_ref_busy", 32'(ref_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst_ref_ar");
        chk("rst_ref_busy", 32'(ref_busy), 32'd0);
        run_init(D_CYC);
        chk("final_qempty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
